// File: rtl/square_renderer.sv
// Bouncing-square overlay. It draws a solid square over the timing generator's raster.
// Once per frame the square moves diagonally and bounces off the screen edges.
module square_renderer #(
  parameter int SQ_SIZE = 32,
  parameter int STEP    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [5:0] rgb,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y
);

  localparam logic [10:0] LIM_X        = 11'(640 - SQ_SIZE);
  localparam logic [10:0] LIM_Y        = 11'(480 - SQ_SIZE);
  localparam logic [10:0] STEP_W       = 11'(STEP);
  localparam logic [10:0] SIZE_W       = 11'(SQ_SIZE);
  localparam logic [9:0]  START_X      = 10'((640 - SQ_SIZE) / 2);
  localparam logic [9:0]  START_Y      = 10'((480 - SQ_SIZE) / 2);
  localparam logic [5:0]  START_COLOUR = 6'h30;

  logic [9:0]  sq_x_q, sq_x_d, sq_y_q, sq_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [5:0]  colour_q, colour_d, rgb_q, rgb_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        frame_tick_q, frame_tick_d;
  logic        is_event, in_x, in_y;
  logic [10:0] x_ext, y_ext, h_ext, v_ext;
  logic [11:0] axis_x, axis_y;

  // Returns {reversed, new_dir, new_pos}. dir=1 means moving towards the limit.
  function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [11:0] r;
    if (dir) begin
      if (pos + STEP_W >= lim) r = {1'b1, 1'b0, lim[9:0]};
      else                     r = {1'b0, 1'b1, 10'(pos + STEP_W)};
    end else begin
      if (pos <= STEP_W) r = {1'b1, 1'b1, 10'd0};
      else               r = {1'b0, 1'b0, 10'(pos - STEP_W)};
    end
    return r;
  endfunction

  always_comb begin
    is_event = (hpos == 10'd0) && (vpos == 10'd480);
    x_ext    = {1'b0, sq_x_q};
    y_ext    = {1'b0, sq_y_q};
    h_ext    = {1'b0, hpos};
    v_ext    = {1'b0, vpos};
    axis_x   = step_axis(x_ext, dir_x_q, LIM_X);
    axis_y   = step_axis(y_ext, dir_y_q, LIM_Y);

    sq_x_d   = sq_x_q;
    sq_y_d   = sq_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    colour_d = colour_q;
    if (is_event && !pause) begin
      sq_x_d  = axis_x[9:0];
      dir_x_d = axis_x[10];
      sq_y_d  = axis_y[9:0];
      dir_y_d = axis_y[10];
      // A corner hit reverses both axes but still advances the colour only once; 0 is skipped.
      if (axis_x[11] || axis_y[11])
        colour_d = (colour_q == 6'd63) ? 6'd1 : colour_q + 6'd1;
    end

    // The hit test uses the position held before this edge's update.
    in_x         = (h_ext >= x_ext) && (h_ext < x_ext + SIZE_W);
    in_y         = (v_ext >= y_ext) && (v_ext < y_ext + SIZE_W);
    rgb_d        = (display_on && in_x && in_y) ? colour_q : 6'h00;
    hsync_d      = hsync_in;
    vsync_d      = vsync_in;
    frame_tick_d = is_event;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_x_q       <= START_X;
      sq_y_q       <= START_Y;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      colour_q     <= START_COLOUR;
      rgb_q        <= 6'h00;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      sq_x_q       <= sq_x_d;
      sq_y_q       <= sq_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      colour_q     <= colour_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign rgb        = rgb_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign frame_tick = frame_tick_q;
  assign sq_x       = sq_x_q;
  assign sq_y       = sq_y_q;

endmodule

// File: tb/tb_square_renderer.sv
// Bench for square_renderer. It runs a default instance and a 240x240 square with 240-pixel steps.
// Every cycle, both instances are compared against a plain integer model of the bounce rules.
module tb_square_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, pause;

  logic [5:0] rgb0, rgb1;
  logic       hs0, hs1, vs0, vs1, tick0, tick1;
  logic [9:0] sqx0, sqx1, sqy0, sqy1;

  int compareCount = 0;
  int failCount    = 0;

  // Behavioural model state, index 0 = default instance, 1 = large instance.
  int mx[2], my[2], mdx[2], mdy[2], mcol[2], mrgb[2], mhs[2], mvs[2], mtick[2];

  always #5 clk = ~clk;

  square_renderer dut0 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .rgb(rgb0), .hsync_out(hs0), .vsync_out(vs0), .frame_tick(tick0),
    .sq_x(sqx0), .sq_y(sqy0)
  );

  square_renderer #(.SQ_SIZE(240), .STEP(240)) dut1 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .rgb(rgb1), .hsync_out(hs1), .vsync_out(vs1), .frame_tick(tick1),
    .sq_x(sqx1), .sq_y(sqy1)
  );

  function automatic int sizeOf(input int i);
    return (i == 0) ? 32 : 240;
  endfunction

  function automatic int stepOf(input int i);
    return (i == 0) ? 2 : 240;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Move one axis: step in the current direction, then clamp at either wall and turn around.
  task automatic moveAxis(inout int pos, inout int dir, input int step, input int lim,
                          output bit rev);
    int np;
    np  = pos + dir * step;
    rev = 1'b0;
    if (np >= lim) begin np = lim; dir = -1; rev = 1'b1; end
    else if (np <= 0) begin np = 0; dir = 1; rev = 1'b1; end
    pos = np;
  endtask

  task automatic modelStep();
    bit rx, ry;
    int sz, h, v;
    h = int'(hpos);
    v = int'(vpos);
    for (int i = 0; i < 2; i++) begin
      sz = sizeOf(i);
      if (reset) begin
        mx[i] = (640 - sz) / 2;  my[i] = (480 - sz) / 2;
        mdx[i] = 1;  mdy[i] = 1;  mcol[i] = 48;
        mrgb[i] = 0; mhs[i] = 1;  mvs[i] = 1;  mtick[i] = 0;
      end else begin
        mrgb[i]  = (display_on && h >= mx[i] && h < mx[i] + sz && v >= my[i] && v < my[i] + sz)
                   ? mcol[i] : 0;
        mhs[i]   = int'(hsync_in);
        mvs[i]   = int'(vsync_in);
        mtick[i] = (h == 0 && v == 480) ? 1 : 0;
        if (mtick[i] == 1 && !pause) begin
          moveAxis(mx[i], mdx[i], stepOf(i), 640 - sz, rx);
          moveAxis(my[i], mdy[i], stepOf(i), 480 - sz, ry);
          if (rx || ry) mcol[i] = (mcol[i] == 63) ? 1 : mcol[i] + 1;
        end
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("rgb0", int'(rgb0), mrgb[0]);   checkOutput("rgb1", int'(rgb1), mrgb[1]);
    checkOutput("sqx0", int'(sqx0), mx[0]);     checkOutput("sqx1", int'(sqx1), mx[1]);
    checkOutput("sqy0", int'(sqy0), my[0]);     checkOutput("sqy1", int'(sqy1), my[1]);
    checkOutput("hs0", int'(hs0), mhs[0]);      checkOutput("hs1", int'(hs1), mhs[1]);
    checkOutput("vs0", int'(vs0), mvs[0]);      checkOutput("vs1", int'(vs1), mvs[1]);
    checkOutput("tick0", int'(tick0), mtick[0]); checkOutput("tick1", int'(tick1), mtick[1]);
  endtask

  // Drive one cycle of inputs away from the edge, advance the model, then compare.
  task automatic applyStimulus(input bit r, input int h, input int v, input bit de,
                               input bit hs, input bit vs, input bit p);
    @(negedge clk);
    reset = r; hpos = 10'(h); vpos = 10'(v); display_on = de;
    hsync_in = hs; vsync_in = vs; pause = p;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic frameEvent(input bit p);
    applyStimulus(1'b0, 0, 480, 1'b0, 1'b1, 1'b0, p);
  endtask

  initial begin
    int bound, savedX, savedY, savedCol, ticks, k, sz, h, v;
    reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; pause = 1'b0;

    // Reset with arbitrary inputs for two cycles.
    applyStimulus(1'b1, 0, 480, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_sqx", int'(sqx0), 304);
    checkOutput("rst_sqy", int'(sqy0), 224);
    checkOutput("rst_rgb", int'(rgb0), 0);
    checkOutput("rst_hs", int'(hs0), 1);
    checkOutput("rst_vs", int'(vs0), 1);
    checkOutput("rst_tick", int'(tick0), 0);
    checkOutput("rst_sqx_big", int'(sqx1), 200);
    checkOutput("rst_sqy_big", int'(sqy1), 120);

    // Pixel hits and misses on the square's edges.
    applyStimulus(1'b0, 304, 224, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pix_corner", int'(rgb0), 6'h30);
    applyStimulus(1'b0, 336, 224, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pix_right", int'(rgb0), 0);
    applyStimulus(1'b0, 303, 224, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pix_left", int'(rgb0), 0);
    applyStimulus(1'b0, 304, 224, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("pix_blank", int'(rgb0), 0);
    applyStimulus(1'b0, 10, 10, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("hsync_delay", int'(hs0), 0);

    // First frame event, then a row-start edge that must not move anything.
    frameEvent(1'b0);
    checkOutput("move_x", int'(sqx0), 306);
    checkOutput("move_y", int'(sqy0), 226);
    checkOutput("move_tick", int'(tick0), 1);
    checkOutput("corner_x_big", int'(sqx1), 400);
    checkOutput("corner_y_big", int'(sqy1), 240);
    applyStimulus(1'b0, 0, 100, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("noE_x", int'(sqx0), 306);
    checkOutput("noE_tick", int'(tick0), 0);
    applyStimulus(1'b0, 400, 240, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("corner_colour", int'(rgb1), 6'h31);

    // Run to the right wall on the default instance.
    bound = 0;
    while (!(mx[0] == 606 && mdx[0] == 1) && bound < 400) begin
      frameEvent(1'b0);
      bound++;
    end
    checkOutput("reach_606", mx[0], 606);
    frameEvent(1'b0);
    checkOutput("bounce_x", int'(sqx0), 608);
    applyStimulus(1'b0, 608, int'(sqy0), 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("bounce_colour", int'(rgb0), mcol[0]);
    frameEvent(1'b0);
    checkOutput("after_bounce_x", int'(sqx0), 606);

    // Pause across three frame events.
    savedX = mx[0]; savedY = my[0]; savedCol = mcol[0]; ticks = 0;
    for (int i = 0; i < 3; i++) begin
      frameEvent(1'b1);
      ticks += int'(tick0);
    end
    checkOutput("pause_x", int'(sqx0), savedX);
    checkOutput("pause_y", int'(sqy0), savedY);
    checkOutput("pause_ticks", ticks, 3);
    applyStimulus(1'b0, savedX, savedY, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("pause_colour", int'(rgb0), savedCol);

    // Colour wrap on the large instance: 63 is followed by 1.
    bound = 0;
    while (mcol[1] != 63 && bound < 80) begin frameEvent(1'b0); bound++; end
    checkOutput("reach_63", mcol[1], 63);
    bound = 0;
    while (mcol[1] == 63 && bound < 80) begin frameEvent(1'b0); bound++; end
    applyStimulus(1'b0, mx[1], my[1], 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("wrap_colour", int'(rgb1), 1);

    // Reset coinciding with a frame event.
    applyStimulus(1'b1, 0, 480, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("rstE_x", int'(sqx0), 304);
    checkOutput("rstE_y", int'(sqy0), 224);
    checkOutput("rstE_tick", int'(tick0), 0);

    // Randomized mix of frame events, pixels near each square, and rare resets.
    for (int n = 0; n < 2500; n++) begin
      k = int'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
      end else if (k < 3) begin
        frameEvent($urandom_range(0, 5) == 0);
      end else if (k == 3) begin
        applyStimulus(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        k  = int'($urandom_range(0, 1));
        sz = sizeOf(k);
        h  = mx[k] + int'($urandom_range(0, sz + 3)) - 2;
        v  = my[k] + int'($urandom_range(0, sz + 3)) - 2;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        applyStimulus(1'b0, h, v, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                      1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
